reg_file: RTL and testbench

- 32 x 32-bit MIPS general register file; responder to the control unit's `rf_raddr1`/`rf_raddr2`/`rf_we`/`rf_waddr` interface.
- Provides two combinational read ports and one synchronous write port. `r0` is hardwired to zero.
- Includes a debug dump engine that streams every register over a valid/ready channel for trace comparison against the golden model.
- Sits between the control unit / writeback mux and the ALU operand path.

---
 rtl/reg_file_if.sv | 65 ++++++
 rtl/reg_file.sv | 162 ++++++++++++++++
 tb/tb_reg_file.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if: bus bundle between the control unit / writeback path and the
// register file. It carries the two read ports, the write port and the
// debug dump valid/ready channel. The member names match the register file's
// original port names.
//   master : control unit, writeback mux and dump sink side
//   slave  : register file side
interface reg_file_if;

    // Read port 1 (rs)
    logic [4:0]  raddr1;
    logic [31:0] rdata1;

    // Read port 2 (rt)
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    // Write port
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    // Debug dump channel
    logic        dump_start;
    logic        dump_busy;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_done;

    modport master (
        output raddr1,
        input  rdata1,
        output raddr2,
        input  rdata2,
        output we,
        output waddr,
        output wdata,
        output dump_start,
        input  dump_busy,
        input  dump_valid,
        output dump_ready,
        input  dump_idx,
        input  dump_data,
        input  dump_done
    );

    modport slave (
        input  raddr1,
        output rdata1,
        input  raddr2,
        output rdata2,
        input  we,
        input  waddr,
        input  wdata,
        input  dump_start,
        output dump_busy,
        output dump_valid,
        input  dump_ready,
        output dump_idx,
        output dump_data,
        output dump_done
    );

endinterface

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit MIPS general register file.
//   - two combinational read ports and one synchronous write port
//   - r0 reads as zero, and writes to it are dropped
//   - debug dump engine that streams r0..r[DUMP_LAST] over a valid/ready channel
// Optional feature macro: RF_WRITE_BYPASS_EN
//   When it is defined, a read of the register being written in the same cycle
//   returns wdata. Define it only for the pipelined datapath. In the
//   single-cycle CPU wdata depends combinationally on rdata, so the bypass
//   would close a combinational loop.
// Reset: synchronous, active-high.
module reg_file #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    parameter int unsigned DUMP_LAST = 31
) (
    input  logic     clk,
    input  logic     reset,
    reg_file_if.slave rf
);

    localparam int unsigned NUM_REGS = 32;
    localparam logic [4:0]  LAST_IDX = 5'(DUMP_LAST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } dump_state_e;

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic        wr_hit;

    // Next array contents: apply the write port, and keep r0 pinned at zero
    always_comb begin
        wr_hit = rf.we && (rf.waddr != '0);
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[rf.waddr] = rf.wdata;
        end
        regs_d[0] = '0;
    end

    // Array storage: r1..r31 load RESET_VAL on reset, and r0 is always zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? '0 : RESET_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic        byp1;
    logic        byp2;
    logic [31:0] rdata1_c;
    logic [31:0] rdata2_c;

    // Combinational read, with an optional same-cycle write bypass
    always_comb begin
`ifdef RF_WRITE_BYPASS_EN
        byp1 = wr_hit && (rf.waddr == rf.raddr1);
        byp2 = wr_hit && (rf.waddr == rf.raddr2);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        if (rf.raddr1 == '0) begin
            rdata1_c = '0;
        end else if (byp1) begin
            rdata1_c = rf.wdata;
        end else begin
            rdata1_c = regs_q[rf.raddr1];
        end

        if (rf.raddr2 == '0) begin
            rdata2_c = '0;
        end else if (byp2) begin
            rdata2_c = rf.wdata;
        end else begin
            rdata2_c = regs_q[rf.raddr2];
        end
    end

    assign rf.rdata1 = rdata1_c;
    assign rf.rdata2 = rdata2_c;

    // ------------------------------------------------------------------
    // Dump engine
    // ------------------------------------------------------------------
    dump_state_e state_q;
    dump_state_e state_d;
    logic [4:0]  dump_idx_q;
    logic [4:0]  dump_idx_d;
    logic [31:0] dump_data_q;
    logic [31:0] dump_data_d;
    logic [4:0]  next_idx;
    logic        beat_accept;

    // Next-state logic: the beat registers advance only when a beat is accepted
    always_comb begin
        state_d     = state_q;
        dump_idx_d  = dump_idx_q;
        dump_data_d = dump_data_q;
        next_idx    = dump_idx_q + 5'd1;
        beat_accept = (state_q == ST_SEND) && rf.dump_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (rf.dump_start) begin
                    state_d     = ST_SEND;
                    dump_idx_d  = '0;
                    dump_data_d = '0;
                end
            end
            ST_SEND: begin
                if (beat_accept) begin
                    if (dump_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        // regs_d already holds this cycle's write, so a write
                        // to the next index is captured in the new beat.
                        dump_idx_d  = next_idx;
                        dump_data_d = regs_d[next_idx];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Dump state and beat registers; reset aborts any dump in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dump_idx_q  <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            dump_idx_q  <= dump_idx_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign rf.dump_valid = (state_q == ST_SEND);
    assign rf.dump_busy  = (state_q != ST_IDLE);
    assign rf.dump_done  = (state_q == ST_DONE);
    assign rf.dump_idx   = dump_idx_q;
    assign rf.dump_data  = dump_data_q;

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file.
// The array is modelled as a plain 32-entry array. The expected dump beats
// follow from the test's own loads.
module tb_reg_file;

    localparam logic [31:0] RV   = 32'hC0DE_0001;
    localparam int unsigned LAST = 31;
`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_file_if rf_bus();

    reg_file #(
        .RESET_VAL(RV),
        .DUMP_LAST(LAST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rf   (rf_bus.slave)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (BYP && rf_bus.we && rf_bus.waddr == ra) return rf_bus.wdata;
        return model[ra];
    endfunction

    task automatic commit();
        if (rf_bus.we && rf_bus.waddr != 5'd0) model[rf_bus.waddr] = rf_bus.wdata;
    endtask

    task automatic idle_inputs();
        rf_bus.we         = 1'b0;
        rf_bus.waddr      = '0;
        rf_bus.wdata      = '0;
        rf_bus.raddr1     = '0;
        rf_bus.raddr2     = '0;
        rf_bus.dump_start = 1'b0;
        rf_bus.dump_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = (i == 0) ? 32'h0 : RV;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        rf_bus.we    = 1'b1;
        rf_bus.waddr = a;
        rf_bus.wdata = d;
        commit();
        step();
        rf_bus.we = 1'b0;
    endtask

    initial begin
        int unsigned exp_idx;
        bit reached;
        bit wrote;

        // Same-cycle read expectations, applied in order after a reset
        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5,
                    BYP ? 32'hDEAD_BEEF : RV, BYP ? 32'hDEAD_BEEF : RV};
        vecs[1] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h1234_5678, 5'd0,  5'd0,  32'h0, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 5'd7,  32'h0,         5'd7,  5'd1,  BYP ? 32'h0 : RV, RV};
        vecs[5] = '{1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd7,
                    BYP ? 32'hA5A5_A5A5 : 32'h0, BYP ? 32'hA5A5_A5A5 : 32'h0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd0,  32'hA5A5_A5A5, 32'h0};
        vecs[7] = '{1'b1, 5'd31, 32'h1,         5'd31, 5'd30, BYP ? 32'h1 : RV, RV};
        vecs[8] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd5,  32'h1, 32'hDEAD_BEEF};

        idle_inputs();
        step();
        do_reset();

        // Reset state: dump outputs and every address on both ports
        #1;
        chk("rst_valid", 32'(rf_bus.dump_valid), 32'h0);
        chk("rst_busy",  32'(rf_bus.dump_busy),  32'h0);
        chk("rst_done",  32'(rf_bus.dump_done),  32'h0);
        chk("rst_idx",   32'(rf_bus.dump_idx),   32'h0);
        chk("rst_data",  rf_bus.dump_data,       32'h0);
        for (int i = 0; i < 32; i++) begin
            rf_bus.raddr1 = 5'(i);
            rf_bus.raddr2 = 5'(31 - i);
            #1;
            chk("rst_rd1", rf_bus.rdata1, (i == 0) ? 32'h0 : RV);
            chk("rst_rd2", rf_bus.rdata2, (i == 31) ? 32'h0 : RV);
        end
        step();

        // Table-driven read/write vectors
        for (int v = 0; v < 9; v++) begin
            rf_bus.we     = vecs[v].we;
            rf_bus.waddr  = vecs[v].wa;
            rf_bus.wdata  = vecs[v].wd;
            rf_bus.raddr1 = vecs[v].ra1;
            rf_bus.raddr2 = vecs[v].ra2;
            #1;
            chk($sformatf("vec%0d_rd1", v), rf_bus.rdata1, vecs[v].e1);
            chk($sformatf("vec%0d_rd2", v), rf_bus.rdata2, vecs[v].e2);
            commit();
            step();
        end
        rf_bus.we = 1'b0;

        // Randomized traffic against the array model
        for (int c = 0; c < 300; c++) begin
            rf_bus.we     = 1'($urandom_range(1, 0));
            rf_bus.waddr  = 5'($urandom_range(31, 0));
            rf_bus.wdata  = $urandom;
            rf_bus.raddr1 = ($urandom_range(3, 0) == 0) ? rf_bus.waddr : 5'($urandom_range(31, 0));
            rf_bus.raddr2 = 5'($urandom_range(31, 0));
            #1;
            chk("rand_rd1", rf_bus.rdata1, exp_read(rf_bus.raddr1));
            chk("rand_rd2", rf_bus.rdata2, exp_read(rf_bus.raddr2));
            commit();
            step();
        end
        rf_bus.we = 1'b0;

        // Full dump with ready held high, and dump_start pulsed mid-dump and in DONE
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i * 16));
        rf_bus.dump_ready = 1'b1;
        rf_bus.dump_start = 1'b1;
        step();
        rf_bus.dump_start = 1'b0;
        for (int k = 0; k <= int'(LAST); k++) begin
            #1;
            chk($sformatf("full_valid%0d", k), 32'(rf_bus.dump_valid), 32'h1);
            chk($sformatf("full_idx%0d", k),   32'(rf_bus.dump_idx),   32'(k));
            chk($sformatf("full_data%0d", k),  rf_bus.dump_data,       32'(k * 16));
            chk($sformatf("full_done%0d", k),  32'(rf_bus.dump_done),  32'h0);
            rf_bus.dump_start = (k == 3);
            step();
        end
        chk("full_done_pulse", 32'(rf_bus.dump_done),  32'h1);
        chk("full_done_busy",  32'(rf_bus.dump_busy),  32'h1);
        chk("full_done_valid", 32'(rf_bus.dump_valid), 32'h0);
        rf_bus.dump_start = 1'b1;
        step();
        rf_bus.dump_start = 1'b0;
        chk("after_done",      32'(rf_bus.dump_done),  32'h0);
        chk("after_busy",      32'(rf_bus.dump_busy),  32'h0);
        step();
        chk("start_in_done_ignored", 32'(rf_bus.dump_busy), 32'h0);
        chk("start_in_done_valid",   32'(rf_bus.dump_valid), 32'h0);

        // Stalled dump: ready pattern 1,0,0, a write to the held index, and reset at beat 10
        rf_bus.dump_ready = 1'b0;
        rf_bus.dump_start = 1'b1;
        step();
        rf_bus.dump_start = 1'b0;
        exp_idx = 0;
        reached = 1'b0;
        wrote   = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            rf_bus.dump_ready = (c % 3 == 0);
            rf_bus.raddr1     = 5'd4;
            #1;
            chk("stall_valid", 32'(rf_bus.dump_valid), 32'h1);
            chk("stall_idx",   32'(rf_bus.dump_idx),   exp_idx);
            chk("stall_data",  rf_bus.dump_data,       exp_idx * 16);
            chk("stall_rd_r4", rf_bus.rdata1,          exp_read(5'd4));
            if (exp_idx == 4 && !rf_bus.dump_ready && !wrote) begin
                rf_bus.we    = 1'b1;
                rf_bus.waddr = 5'd4;
                rf_bus.wdata = 32'hFFFF_0000;
                wrote        = 1'b1;
            end
            if (exp_idx == 10) begin
                reset   = 1'b1;
                reached = 1'b1;
            end
            commit();
            step();
            rf_bus.we = 1'b0;
            if (rf_bus.dump_ready && !reached) exp_idx++;
        end
        chk("stall_reached_beat10", exp_idx, 32'd10);
        reset = 1'b0;
        rf_bus.dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = (i == 0) ? 32'h0 : RV;
        chk("abort_valid", 32'(rf_bus.dump_valid), 32'h0);
        chk("abort_busy",  32'(rf_bus.dump_busy),  32'h0);
        chk("abort_done",  32'(rf_bus.dump_done),  32'h0);
        chk("abort_idx",   32'(rf_bus.dump_idx),   32'h0);
        chk("abort_data",  rf_bus.dump_data,       32'h0);
        for (int c = 0; c < 3; c++) begin
            rf_bus.raddr1 = 5'd4;
            rf_bus.raddr2 = 5'd10;
            #1;
            chk("abort_no_done", 32'(rf_bus.dump_done), 32'h0);
            chk("abort_idle",    32'(rf_bus.dump_busy), 32'h0);
            chk("abort_r4",      rf_bus.rdata1, exp_read(5'd4));
            chk("abort_r10",     rf_bus.rdata2, exp_read(5'd10));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
